// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register-file write port between pipeline writeback and the MDU,
// with a starvation-forced one-cycle stall and a pending-result scoreboard for RAW detection.
module regfile_write_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_we,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  input  logic        mdu_issue,
  input  logic [4:0]  mdu_issue_reg,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_reg,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  output logic        regWrite,
  output logic [4:0]  writeRegister,
  output logic [31:0] writeData,
  output logic        pipe_stall,
  input  logic [4:0]  chk_rs,
  input  logic [4:0]  chk_rt,
  output logic        hazard,
  output logic [31:0] pending
);

  localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);
  localparam logic [3:0] LIMIT_M1 = 4'(STARVE_LIMIT - 1);

  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        pipe_stall_q, pipe_stall_d;
  logic [31:0] pending_q, pending_d;
  logic        sel_wb, sel_mdu;

  always_comb begin
    sel_wb        = 1'b0;
    sel_mdu       = 1'b0;
    mdu_ready     = 1'b0;
    regWrite      = 1'b0;
    writeRegister = '0;
    writeData     = '0;
    if (rst) begin
      sel_wb    = ~pipe_stall_q & wb_we;
      sel_mdu   = pipe_stall_q | (~wb_we & mdu_valid);
      mdu_ready = sel_mdu & mdu_valid;
      if (sel_wb) begin
        writeRegister = wb_reg;
        writeData     = wb_data;
        regWrite      = (wb_reg != 5'd0);
      end else if (mdu_ready) begin
        // A stall cycle with mdu_valid low grants nothing writable.
        writeRegister = mdu_reg;
        writeData     = mdu_data;
        regWrite      = (mdu_reg != 5'd0);
      end
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!mdu_valid || mdu_ready) begin
      starve_cnt_d = 4'd0;
    end else if (starve_cnt_q != LIMIT) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
    pipe_stall_d = mdu_valid & ~mdu_ready & (starve_cnt_q == LIMIT_M1) & ~pipe_stall_q;
  end

  always_comb begin
    pending_d = pending_q;
    if (mdu_ready) begin
      pending_d[mdu_reg] = 1'b0;
    end
    // Issue applied after clear so a same-edge set wins.
    if (mdu_issue) begin
      pending_d[mdu_issue_reg] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_q <= 4'd0;
      pipe_stall_q <= 1'b0;
      pending_q    <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      pipe_stall_q <= pipe_stall_d;
      pending_q    <= pending_d;
    end
  end

  assign pipe_stall = pipe_stall_q;
  assign pending    = pending_q;
  assign hazard     = pending_q[chk_rs] | pending_q[chk_rt];

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: per-cycle expectations are queued when
// stimulus is driven and popped/compared when outputs settle on the falling edge.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        mdu_issue;
  logic [4:0]  mdu_issue_reg;
  logic        mdu_valid;
  logic [4:0]  mdu_reg;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        regWrite;
  logic [4:0]  writeRegister;
  logic [31:0] writeData;
  logic        pipe_stall;
  logic [4:0]  chk_rs;
  logic [4:0]  chk_rt;
  logic        hazard;
  logic [31:0] pending;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       tag;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        rdy;
    logic        stall;
    logic        hz;
    logic [31:0] pend;
  } exp_t;

  exp_t exp_q[$];

  regfile_write_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .wb_we         (wb_we),
    .wb_reg        (wb_reg),
    .wb_data       (wb_data),
    .mdu_issue     (mdu_issue),
    .mdu_issue_reg (mdu_issue_reg),
    .mdu_valid     (mdu_valid),
    .mdu_reg       (mdu_reg),
    .mdu_data      (mdu_data),
    .mdu_ready     (mdu_ready),
    .regWrite      (regWrite),
    .writeRegister (writeRegister),
    .writeData     (writeData),
    .pipe_stall    (pipe_stall),
    .chk_rs        (chk_rs),
    .chk_rt        (chk_rt),
    .hazard        (hazard),
    .pending       (pending)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h, required 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wb_we = 1'b0; wb_reg = '0; wb_data = '0;
    mdu_issue = 1'b0; mdu_issue_reg = '0;
    mdu_valid = 1'b0; mdu_reg = '0; mdu_data = '0;
    chk_rs = '0; chk_rt = '0;
  endtask

  // Queue one cycle's expectation, compare at the falling edge, then step past the rising edge.
  task automatic cyc(input string tag, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic rdy, input logic stall, input logic hz, input logic [31:0] pend);
    exp_t e;
    exp_t g;
    e.tag = tag; e.we = we; e.wa = wa; e.wd = wd;
    e.rdy = rdy; e.stall = stall; e.hz = hz; e.pend = pend;
    exp_q.push_back(e);
    @(negedge clk);
    g = exp_q.pop_front();
    chk({g.tag, ".regWrite"},      32'(regWrite),      32'(g.we));
    chk({g.tag, ".writeRegister"}, 32'(writeRegister), 32'(g.wa));
    chk({g.tag, ".writeData"},     writeData,          g.wd);
    chk({g.tag, ".mdu_ready"},     32'(mdu_ready),     32'(g.rdy));
    chk({g.tag, ".pipe_stall"},    32'(pipe_stall),    32'(g.stall));
    chk({g.tag, ".hazard"},        32'(hazard),        32'(g.hz));
    chk({g.tag, ".pending"},       pending,            g.pend);
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] P12 = 32'h0000_1000;
  localparam logic [31:0] P4  = 32'h0000_0010;

  initial begin
    rst = 1'b0;
    idle();
    wb_we = 1'b1; wb_reg = 5'd5; wb_data = 32'hDEAD_BEEF;
    cyc("rst_hold", 0, 5'd0, 32'd0, 0, 0, 0, 32'd0);
    cyc("rst_hold2", 0, 5'd0, 32'd0, 0, 0, 0, 32'd0);
    idle();
    rst = 1'b1;
    cyc("idle", 0, 5'd0, 32'd0, 0, 0, 0, 32'd0);

    // Priority: WB beats a waiting MDU, MDU wins once WB is quiet.
    wb_we = 1'b1; wb_reg = 5'd3; wb_data = 32'hAAAA_0000;
    mdu_valid = 1'b1; mdu_reg = 5'd7; mdu_data = 32'h0000_1234;
    cyc("prio_wb", 1, 5'd3, 32'hAAAA_0000, 0, 0, 0, 32'd0);
    wb_we = 1'b0;
    cyc("prio_mdu", 1, 5'd7, 32'h0000_1234, 1, 0, 0, 32'd0);
    idle();
    cyc("prio_idle", 0, 5'd0, 32'd0, 0, 0, 0, 32'd0);

    // Starvation: four blocked cycles, then a forced stall that retires r9.
    wb_we = 1'b1; wb_reg = 5'd1; wb_data = 32'h0000_0011;
    mdu_valid = 1'b1; mdu_reg = 5'd9; mdu_data = 32'h0000_0099;
    for (int i = 0; i < 4; i++) cyc($sformatf("starve_c%0d", i), 1, 5'd1, 32'h11, 0, 0, 0, 32'd0);
    cyc("starve_c4", 1, 5'd9, 32'h99, 1, 1, 0, 32'd0);
    // Back-to-back result: counter must restart from zero after the handshake.
    mdu_reg = 5'd10; mdu_data = 32'h0000_00A0;
    for (int i = 5; i < 9; i++) cyc($sformatf("starve_c%0d", i), 1, 5'd1, 32'h11, 0, 0, 0, 32'd0);
    cyc("starve_c9", 1, 5'd10, 32'hA0, 1, 1, 0, 32'd0);
    mdu_valid = 1'b0;
    cyc("starve_c10", 1, 5'd1, 32'h11, 0, 0, 0, 32'd0);
    idle();

    // Scoreboard: no same-cycle bypass, hazard held until after the handshake.
    mdu_issue = 1'b1; mdu_issue_reg = 5'd12; chk_rs = 5'd12;
    cyc("sb_issue", 0, 5'd0, 32'd0, 0, 0, 0, 32'd0);
    mdu_issue = 1'b0;
    cyc("sb_pend", 0, 5'd0, 32'd0, 0, 0, 1, P12);
    chk_rs = 5'd0; chk_rt = 5'd12;
    wb_we = 1'b1; wb_reg = 5'd12; wb_data = 32'h0000_0C0C;
    cyc("sb_wb_pending", 1, 5'd12, 32'h0C0C, 0, 0, 1, P12);
    wb_we = 1'b0; chk_rt = 5'd0; chk_rs = 5'd12;
    cyc("sb_wb_noclear", 0, 5'd0, 32'd0, 0, 0, 1, P12);
    mdu_valid = 1'b1; mdu_reg = 5'd12; mdu_data = 32'h0000_C000;
    cyc("sb_hs", 1, 5'd12, 32'hC000, 1, 0, 1, P12);
    mdu_valid = 1'b0;
    cyc("sb_clear", 0, 5'd0, 32'd0, 0, 0, 0, 32'd0);
    mdu_issue = 1'b1; mdu_issue_reg = 5'd0; chk_rs = 5'd0;
    cyc("sb_r0_issue", 0, 5'd0, 32'd0, 0, 0, 0, 32'd0);
    mdu_issue = 1'b0;
    cyc("sb_r0_after", 0, 5'd0, 32'd0, 0, 0, 0, 32'd0);

    // Simultaneous set and clear of r12: set wins.
    mdu_issue = 1'b1; mdu_issue_reg = 5'd12; chk_rs = 5'd12;
    cyc("sc_issue", 0, 5'd0, 32'd0, 0, 0, 0, 32'd0);
    mdu_valid = 1'b1; mdu_reg = 5'd12; mdu_data = 32'h0000_0012;
    cyc("sc_both", 1, 5'd12, 32'h12, 1, 0, 1, P12);
    mdu_issue = 1'b0; mdu_data = 32'h0000_0112;
    cyc("sc_still", 1, 5'd12, 32'h112, 1, 0, 1, P12);
    idle();
    cyc("sc_clear", 0, 5'd0, 32'd0, 0, 0, 0, 32'd0);

    // Register 0: writes dropped, MDU still handshakes.
    wb_we = 1'b1; wb_reg = 5'd0; wb_data = 32'h0000_5555;
    cyc("r0_wb", 0, 5'd0, 32'h5555, 0, 0, 0, 32'd0);
    wb_we = 1'b0;
    mdu_valid = 1'b1; mdu_reg = 5'd0; mdu_data = 32'h0000_6666;
    cyc("r0_mdu", 0, 5'd0, 32'h6666, 1, 0, 0, 32'd0);
    idle();

    // mdu_valid dropped during a stall: one-cycle stall, no write.
    wb_we = 1'b1; wb_reg = 5'd2; wb_data = 32'h0000_0022;
    mdu_valid = 1'b1; mdu_reg = 5'd9; mdu_data = 32'h0000_0099;
    for (int i = 0; i < 4; i++) cyc($sformatf("pv_c%0d", i), 1, 5'd2, 32'h22, 0, 0, 0, 32'd0);
    mdu_valid = 1'b0;
    cyc("pv_stall", 0, 5'd0, 32'd0, 0, 1, 0, 32'd0);
    cyc("pv_after", 1, 5'd2, 32'h22, 0, 0, 0, 32'd0);

    // Reset mid-stall with a pending bit set.
    mdu_valid = 1'b1; mdu_issue = 1'b1; mdu_issue_reg = 5'd4; chk_rs = 5'd4;
    cyc("rs_c0", 1, 5'd2, 32'h22, 0, 0, 0, 32'd0);
    mdu_issue = 1'b0;
    for (int i = 1; i < 4; i++) cyc($sformatf("rs_c%0d", i), 1, 5'd2, 32'h22, 0, 0, 1, P4);
    rst = 1'b0;
    cyc("rs_in_reset", 0, 5'd0, 32'd0, 0, 0, 0, 32'd0);
    idle();
    chk_rs = 5'd4;
    rst = 1'b1;
    cyc("rs_release", 0, 5'd0, 32'd0, 0, 0, 0, 32'd0);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single write port of the pipelined register file between two sources: the main pipeline writeback stage and the multi-cycle multiply/divide unit (MDU). The main pipeline has fixed priority. A starvation counter forces a one-cycle pipeline stall so a blocked MDU result always retires. A 32-entry pending scoreboard tracks registers with outstanding MDU results so decode can detect RAW hazards.

## Interface
- STARVE_LIMIT, 4: number of consecutive blocked MDU cycles before a stall is forced (legal range 1–15).
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- wb_we  input  1  pipeline writeback request.
- wb_reg  input  5  pipeline destination register.
- wb_data  input  32  pipeline write data.
- mdu_issue  input  1  an MDU op is issued this cycle.
- mdu_issue_reg  input  5  destination register of the issued MDU op.
- mdu_valid  input  1  MDU result available.
- mdu_reg  input  5  MDU result destination register.
- mdu_data  input  32  MDU result data.
- mdu_ready  output  1  MDU result accepted this cycle.
- regWrite  output  1  register-file write enable.
- writeRegister  output  5  register-file write address.
- writeData  output  32  register-file write data.
- pipe_stall  output  1  registered; pipeline must freeze writeback this cycle.
- chk_rs, chk_rt  input  5 each  decode source registers.
- hazard  output  1  either decode source is pending.
- pending  output  32  scoreboard bitmask.

## Operation
- Grant selection (combinational), evaluated in priority order:
  1. If pipe_stall=1: grant MDU. wb_* inputs are ignored, and the pipeline re-presents the same write next cycle.
  2. Else if wb_we=1: grant WB.
  3. Else if mdu_valid=1: grant MDU.
  4. Else: no grant.
- mdu_ready = mdu_valid AND MDU granted.
- An MDU handshake completes on a cycle with mdu_valid=1 and mdu_ready=1.
- mdu_valid, mdu_reg and mdu_data must be held stable until the handshake completes.
- Write outputs:
  - writeRegister and writeData come from the granted source; they are 0 when there is no grant.
  - regWrite = grant AND granted register != 0.
  - A register-0 write is dropped, but an MDU result to register 0 still handshakes.
- Starvation counter starve_cnt (4-bit):
  - Increments on each cycle with mdu_valid=1 and mdu_ready=0.
  - Clears to 0 on an MDU handshake or when mdu_valid=0.
  - Saturates at STARVE_LIMIT.
- Next-state rule for pipe_stall: pipe_stall_next = mdu_valid AND NOT mdu_ready AND (starve_cnt == STARVE_LIMIT-1) AND NOT pipe_stall.
  - pipe_stall is therefore high for exactly one cycle, never back-to-back.
  - If mdu_valid drops during a stall cycle (a protocol violation), the stall still lasts one cycle and no write occurs.
- Scoreboard:
  - pending[r] sets on mdu_issue with mdu_issue_reg=r, for r != 0.
  - pending[r] clears on an MDU handshake with mdu_reg=r.
  - Set and clear of the same r on the same edge: set wins.
  - A WB write to a pending register does not clear its bit.
  - pending[0] is always 0.
- hazard = pending[chk_rs] OR pending[chk_rt]. It reflects the registered scoreboard only; there is no same-cycle bypass of mdu_issue.

## Timing
- Reset (rst=0, asynchronous):
  - pending = 0, starve_cnt = 0, pipe_stall = 0.
  - regWrite and mdu_ready are forced to 0 while rst=0.
  - Reset asserted mid-stall or mid-handshake: the in-flight result is discarded. The MDU must also be reset.
- Grant, mdu_ready, regWrite, writeRegister, writeData: same-cycle combinational. The register file commits on the same rising edge.
- Scoreboard update: visible on hazard/pending one cycle after the issue or handshake edge.
- Worst-case MDU wait from mdu_valid rising to handshake: STARVE_LIMIT+1 cycles.
- pipe_stall: registered, asserted the cycle after the STARVE_LIMIT-th blocked cycle.

## Test plan
- Reset and idle:
  - Stimulus: hold rst=0 while driving wb_we=1 with wb_reg=5.
  - Required: regWrite=0, pending=0, pipe_stall=0.
  - After release, with all inputs idle: all outputs 0.
- Priority:
  - Stimulus: wb_we=1, wb_reg=3, wb_data=0xAAAA0000 while mdu_valid=1, mdu_reg=7, mdu_data=0x1234.
  - Required: write to r3, mdu_ready=0.
  - Next cycle with wb_we=0: write r7=0x1234, mdu_ready=1.
- Starvation with STARVE_LIMIT=4:
  - Stimulus: wb_we=1 continuously; mdu_valid=1 (mdu_reg=9) from cycle 0.
  - Required: pipe_stall=1 in cycle 4 only, with r9 written in cycle 4.
  - Cycle 5: WB granted again; starve_cnt=0.
- Scoreboard:
  - Stimulus: mdu_issue with mdu_issue_reg=12; check chk_rs=12.
  - Required: hazard=1 from the next cycle, held until the cycle after the r12 handshake.
  - mdu_issue to r0 leaves pending=0.
- Simultaneous set/clear:
  - Stimulus: handshake of r12 on the same edge as mdu_issue of r12.
  - Required: pending[12] remains 1.
- Register 0:
  - Stimulus: wb_we=1 with wb_reg=0; separately, an MDU result to r0.
  - Required: regWrite=0 in both cases; the MDU still receives mdu_ready=1.
